asymmetric_bram_fifo_ctrl: RTL



---
 rtl/asymmetric_bram_fifo_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/asymmetric_bram_fifo_ctrl.sv
// Width-down-converting FIFO controller for a simple-dual-port asymmetric BRAM.
// Wide words are written through the write port. Narrow items are read back
// through the read port into a small skid buffer that drives the dequeue
// handshake. Pointers are one bit wider than the address so that full and
// empty can be told apart.
module asymmetric_bram_fifo_ctrl #(
    parameter int WADDR_WIDTH = 4,
    parameter int RATIO_LOG2  = 2,
    parameter int RDATA_WIDTH = 8,
    parameter int PIPELINED   = 0,
    localparam int WDATA_WIDTH = RDATA_WIDTH << RATIO_LOG2,
    localparam int RADDR_WIDTH = WADDR_WIDTH + RATIO_LOG2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [WDATA_WIDTH-1:0] ENQ_DATA,
    input  logic                   ENQ_VALID,
    output logic                   ENQ_READY,
    output logic [RDATA_WIDTH-1:0] DEQ_DATA,
    output logic                   DEQ_VALID,
    input  logic                   DEQ_READY,
    output logic [RADDR_WIDTH:0]   COUNT,
    output logic [WADDR_WIDTH-1:0] BRAM_WADDR,
    output logic [WDATA_WIDTH-1:0] BRAM_WDATA,
    output logic                   BRAM_WEN,
    output logic [RADDR_WIDTH-1:0] BRAM_RADDR,
    output logic                   BRAM_REN,
    input  logic [RDATA_WIDTH-1:0] BRAM_RDATA
);

    // Read latency of the BRAM and the skid depth that covers it.
    localparam int SKID_DEPTH = 2 + PIPELINED;
    localparam int LAT        = 1 + PIPELINED;
    localparam int SW         = $clog2(SKID_DEPTH);
    localparam int CW         = $clog2(SKID_DEPTH + 1) + 1;

    localparam logic [WADDR_WIDTH:0] WUSED_MAX  = {1'b0, {WADDR_WIDTH{1'b1}}};
    localparam logic [SW-1:0]        SKID_LAST  = SW'(SKID_DEPTH - 1);
    localparam logic [CW-1:0]        SKID_LIMIT = CW'(SKID_DEPTH);

    // Pointers: write, committed write, read-issue, dequeue.
    logic [WADDR_WIDTH:0]   wptr, cwptr, wptr_next, used_next;
    logic [RADDR_WIDTH:0]   iptr, dptr, dptr_next, readable;
    logic [RADDR_WIDTH:0]   count_q, count_next;
    logic                   enq_ready_q, enq_ready_d;
    logic                   enq_fire, deq_fire, ren, capture;
    logic [LAT-1:0]         infl;
    logic [CW-1:0]          skid_cnt, infl_cnt, occ;
    logic [RDATA_WIDTH-1:0] skid_mem [SKID_DEPTH];
    logic [SW-1:0]          head, tail;
    logic [RADDR_WIDTH-1:0] raddr_hold;

    // Handshakes and BRAM port drive. Both ready/valid are forced low in reset.
    assign ENQ_READY  = enq_ready_q & ~RST;
    assign enq_fire   = ENQ_VALID & ENQ_READY;
    assign BRAM_WEN   = enq_fire;
    assign BRAM_WADDR = wptr[WADDR_WIDTH-1:0];
    assign BRAM_WDATA = ENQ_DATA;

    assign DEQ_VALID  = ~RST & (skid_cnt != '0);
    assign DEQ_DATA   = skid_mem[head];
    assign deq_fire   = DEQ_VALID & DEQ_READY;

    assign capture    = infl[LAT-1];
    assign BRAM_REN   = ren;
    assign BRAM_RADDR = ren ? iptr[RADDR_WIDTH-1:0] : raddr_hold;
    assign COUNT      = count_q;

    // Next-state pointers, occupancy, and the read-issue decision.
    always_comb begin
        // NOTE: every signal written here gets an unconditional assignment first, so no latch can be inferred.
        wptr_next   = wptr + (WADDR_WIDTH+1)'(enq_fire);
        dptr_next   = dptr + (RADDR_WIDTH+1)'(deq_fire);
        // A wide slot frees only once all of its lanes have been dequeued.
        used_next   = wptr_next - dptr_next[RADDR_WIDTH:RATIO_LOG2];
        enq_ready_d = (used_next <= WUSED_MAX);
        count_next  = ((RADDR_WIDTH+1)'(wptr_next) << RATIO_LOG2) - dptr_next;
        readable    = ((RADDR_WIDTH+1)'(cwptr) << RATIO_LOG2) - iptr;
        infl_cnt    = '0;
        for (int i = 0; i < LAT; i++) begin
            infl_cnt = infl_cnt + CW'(infl[i]);
        end
        // The entry leaving this cycle is already free, which keeps one item per cycle sustained.
        occ = skid_cnt + infl_cnt - CW'(deq_fire);
        ren = ~RST & (readable != '0) & (occ < SKID_LIMIT);
    end

    // Pointer, occupancy, full-flag and read-latency tracking registers.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (RST) begin
            wptr        <= '0;
            cwptr       <= '0;
            iptr        <= '0;
            dptr        <= '0;
            infl        <= '0;
            count_q     <= '0;
            enq_ready_q <= 1'b1;
            raddr_hold  <= '0;
        end else begin
            wptr        <= wptr_next;
            // The write lands in the BRAM at this edge; reads of it are safe from the next cycle.
            cwptr       <= wptr_next;
            iptr        <= iptr + (RADDR_WIDTH+1)'(ren);
            dptr        <= dptr_next;
            count_q     <= count_next;
            enq_ready_q <= enq_ready_d;
            raddr_hold  <= BRAM_RADDR;
            infl[0]     <= ren;
            for (int i = 1; i < LAT; i++) begin
                infl[i] <= infl[i-1];
            end
        end
    end

    // Skid buffer: captures returning BRAM data, presents the head item.
    always_ff @(posedge CLK) begin
        if (RST) begin
            head     <= '0;
            tail     <= '0;
            skid_cnt <= '0;
            // NOTE: the skid entries are a handful of flops, so they are cleared; a real RAM array would not be.
            for (int i = 0; i < SKID_DEPTH; i++) begin
                skid_mem[i] <= '0;
            end
        end else begin
            if (capture) begin
                skid_mem[tail] <= BRAM_RDATA;
                tail           <= (tail == SKID_LAST) ? '0 : tail + SW'(1);
            end
            if (deq_fire) begin
                head <= (head == SKID_LAST) ? '0 : head + SW'(1);
            end
            skid_cnt <= skid_cnt + CW'(capture) - CW'(deq_fire);
        end
    end

endmodule
